// File: rtl/mt9v032_embed_enc_if.sv
// Signal bundle between a parallel pixel source and the MT9V032 embedded-sync encoder.
interface mt9v032_embed_enc_if;
    logic [9:0] px_in;
    logic       line_valid_in;
    logic       frame_valid_in;
    logic [9:0] data_out;
    logic       err;

    modport master (
        output px_in,
        output line_valid_in,
        output frame_valid_in,
        input  data_out,
        input  err
    );

    modport slave (
        input  px_in,
        input  line_valid_in,
        input  frame_valid_in,
        output data_out,
        output err
    );
endinterface

// File: rtl/mt9v032_embed_enc.sv
// Parallel pixel stream to MT9V032-style 10-bit word stream with embedded sync codes.
// Optional framing-violation detection is built when MT9V032_ENC_ERR_EN is defined.
module mt9v032_embed_enc #(
    parameter logic [9:0] BLANK_WORD = 10'd0
) (
    input logic                clk,
    input logic                rst_n,
    mt9v032_embed_enc_if.slave bus_io
);
    localparam int unsigned Depth = 4;

    localparam logic [9:0] CodeFrameEnd  = 10'd3;
    localparam logic [9:0] CodeLineEnd   = 10'd2;
    localparam logic [9:0] CodeLineStart = 10'd1;
    localparam logic [9:0] CodeFrameHi   = 10'd1023;
    localparam logic [9:0] CodeFrameLo   = 10'd0;
    localparam logic [9:0] PixelFloor    = 10'd4;

    // Stage 0 holds the newest slot, stage Depth-1 the slot being encoded.
    logic [9:0]       px_q [Depth];
    logic [9:0]       px_d [Depth];
    logic [Depth-1:0] lv_q, lv_d;
    logic [Depth-1:0] fv_q, fv_d;
    logic             lv_prev_q, fv_prev_q;
    logic [9:0]       data_q, data_d;
    logic             err_q, err_d;

    // Window bit 0 = slot s-1, bit 1 = slot s, up to bit 5 = slot s+4 (live input).
    logic [5:0] fv_w;
    logic [2:0] lv_w;
    logic [2:0] pix_w;

    assign fv_w  = {bus_io.frame_valid_in, fv_q[0], fv_q[1], fv_q[2], fv_q[3], fv_prev_q};
    assign lv_w  = {lv_q[2], lv_q[3], lv_prev_q};
    assign pix_w = lv_w & fv_w[2:0];

    logic c_pix, c_fall, c_end, c_rise_ff, c_rise_0, c_start;

    always_comb begin
        c_pix     = pix_w[1];
        c_fall    = ~fv_w[1] & fv_w[0];
        c_end     = pix_w[0] & fv_w[1];
        // Slot s sits at f-4 or f-2 (1023) or at f-3 (0) ahead of a frame rise f.
        c_rise_ff = (fv_w[5] & ~fv_w[4]) | (fv_w[3] & ~fv_w[2]);
        c_rise_0  = fv_w[4] & ~fv_w[3];
        c_start   = pix_w[2];
    end

    always_comb begin
        px_d[0] = bus_io.px_in;
        for (int i = 1; i < Depth; i++) begin
            px_d[i] = px_q[i-1];
        end
        lv_d = {lv_q[Depth-2:0], bus_io.line_valid_in};
        fv_d = {fv_q[Depth-2:0], bus_io.frame_valid_in};
    end

    always_comb begin
        data_d = BLANK_WORD;
        if (c_pix) begin
            data_d = (px_q[Depth-1] <= PixelFloor) ? PixelFloor : px_q[Depth-1];
        end else if (c_fall) begin
            data_d = CodeFrameEnd;
        end else if (c_end) begin
            data_d = CodeLineEnd;
        end else if (c_rise_ff) begin
            data_d = CodeFrameHi;
        end else if (c_rise_0) begin
            data_d = CodeFrameLo;
        end else if (c_start) begin
            data_d = CodeLineStart;
        end
    end

`ifdef MT9V032_ENC_ERR_EN
    logic [4:0] codes;
    logic       multi_code;
    logic       viol;

    always_comb begin
        codes      = {c_fall, c_end, c_rise_ff, c_rise_0, c_start};
        multi_code = (codes & (codes - 5'd1)) != 5'd0;
        // Line codes under a pixel are normal mid-line; only frame codes collide with pixels.
        viol       = (c_pix ? (c_rise_ff | c_rise_0) : multi_code) | (lv_w[1] & ~fv_w[1]);
        err_d      = err_q | viol;
    end
`else
    assign err_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                px_q[i] <= '0;
            end
            lv_q      <= '0;
            fv_q      <= '0;
            lv_prev_q <= 1'b0;
            fv_prev_q <= 1'b0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < Depth; i++) begin
                px_q[i] <= px_d[i];
            end
            lv_q      <= lv_d;
            fv_q      <= fv_d;
            lv_prev_q <= lv_q[Depth-1];
            fv_prev_q <= fv_q[Depth-1];
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    assign bus_io.data_out = data_q;
    assign bus_io.err      = err_q;
endmodule

// File: tb/tb_mt9v032_embed_enc.sv
// Bench for mt9v032_embed_enc: directed tables plus randomized stream against a slot-level model.
module tb_mt9v032_embed_enc;
    localparam logic [9:0] BW = 10'd7;
    localparam int J = 555;  // don't-care pixel value on non-pixel slots
`ifdef MT9V032_ENC_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    typedef struct {
        bit         fv;
        bit         lv;
        logic [9:0] px;
        logic [9:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mt9v032_embed_enc_if bus ();

    mt9v032_embed_enc #(
        .BLANK_WORD(BW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus)
    );

    vec_t       tbl_a[$];
    vec_t       tbl_b[$];
    bit         m_fv[$];
    bit         m_lv[$];
    logic [9:0] m_px[$];
    bit         m_err;
    int         n_chk;
    int         n_err;

    function automatic vec_t v(input bit fv, input bit lv, input int px, input int exp);
        vec_t r;
        r.fv  = fv;
        r.lv  = lv;
        r.px  = 10'(px);
        r.exp = 10'(exp);
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slot history indexed by absolute slot number since reset; 5 cleared slots seed it.
    function automatic void model_reset();
        m_fv.delete();
        m_lv.delete();
        m_px.delete();
        for (int i = 0; i < 5; i++) begin
            m_fv.push_back(1'b0);
            m_lv.push_back(1'b0);
            m_px.push_back(10'd0);
        end
        m_err = 1'b0;
    endfunction

    function automatic bit pix(input int i);
        return m_lv[i] && m_fv[i];
    endfunction

    function automatic bit rise(input int i);
        return m_fv[i] && !m_fv[i-1];
    endfunction

    task automatic model_word(input int s, output logic [9:0] w, output bit vio);
        bit r1, r2, r3, r4, r5, r6;
        r1 = pix(s);
        r2 = !m_fv[s] && m_fv[s-1];
        r3 = pix(s-1) && m_fv[s];
        r4 = rise(s+4) || rise(s+2);
        r5 = rise(s+3);
        r6 = pix(s+1);
        if (r1)      w = (m_px[s] <= 10'd4) ? 10'd4 : m_px[s];
        else if (r2) w = 10'd3;
        else if (r3) w = 10'd2;
        else if (r4) w = 10'd1023;
        else if (r5) w = 10'd0;
        else if (r6) w = 10'd1;
        else         w = BW;
        if (r1) vio = r4 || r5;
        else    vio = $countones({r2, r3, r4, r5, r6}) > 1;
        vio = vio || (m_lv[s] && !m_fv[s]);
    endtask

    task automatic step(input bit rst, input bit fv, input bit lv, input logic [9:0] px);
        logic [9:0] w;
        bit         vio;
        rst_n              = !rst;
        bus.frame_valid_in = fv;
        bus.line_valid_in  = lv;
        bus.px_in          = px;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
            check("reset data_out", bus.data_out, 0);
            check("reset err", bus.err, 0);
        end else begin
            m_fv.push_back(fv);
            m_lv.push_back(lv);
            m_px.push_back(px);
            model_word(m_fv.size() - 5, w, vio);
            m_err = m_err | vio;
            check("model data_out", bus.data_out, w);
            check("model err", bus.err, ErrEn ? int'(m_err) : 0);
        end
    endtask

    task automatic apply_tbl(input bit sel, input string name);
        int   n;
        vec_t cur;
        vec_t old;
        n = sel ? tbl_b.size() : tbl_a.size();
        for (int i = 0; i < n + 4; i++) begin
            if (i < n) cur = sel ? tbl_b[i] : tbl_a[i];
            else       cur = v(0, 0, J, BW);
            step(1'b0, cur.fv, cur.lv, cur.px);
            if (i >= 4) begin
                old = sel ? tbl_b[i-4] : tbl_a[i-4];
                check(name, bus.data_out, old.exp);
            end
        end
    endtask

    initial begin
        bit         fv_s;
        bit         lv_s;
        bit         r;
        logic [9:0] p;
        n_chk = 0;
        n_err = 0;
        fv_s  = 1'b0;
        lv_s  = 1'b0;
        model_reset();

        // Frame test: 2 lines of 10,20,30, lv gap 4, fv falls with the last lv.
        tbl_a.push_back(v(0, 0, J, BW));   tbl_a.push_back(v(0, 0, J, BW));
        tbl_a.push_back(v(0, 0, J, 1023)); tbl_a.push_back(v(0, 0, J, 0));
        tbl_a.push_back(v(0, 0, J, 1023)); tbl_a.push_back(v(0, 0, J, BW));
        tbl_a.push_back(v(1, 0, J, 1));
        tbl_a.push_back(v(1, 1, 10, 10));  tbl_a.push_back(v(1, 1, 20, 20));
        tbl_a.push_back(v(1, 1, 30, 30));  tbl_a.push_back(v(1, 0, J, 2));
        tbl_a.push_back(v(1, 0, J, BW));   tbl_a.push_back(v(1, 0, J, BW));
        tbl_a.push_back(v(1, 0, J, 1));
        tbl_a.push_back(v(1, 1, 10, 10));  tbl_a.push_back(v(1, 1, 20, 20));
        tbl_a.push_back(v(1, 1, 30, 30));  tbl_a.push_back(v(0, 0, J, 3));

        // Clamp line (lv rises with fv), late frame fall, then a 1-slot line gap.
        tbl_b.push_back(v(0, 0, J, BW));   tbl_b.push_back(v(0, 0, J, 1023));
        tbl_b.push_back(v(0, 0, J, 0));    tbl_b.push_back(v(0, 0, J, 1023));
        tbl_b.push_back(v(0, 0, J, 1));
        tbl_b.push_back(v(1, 1, 0, 4));    tbl_b.push_back(v(1, 1, 1, 4));
        tbl_b.push_back(v(1, 1, 3, 4));    tbl_b.push_back(v(1, 1, 4, 4));
        tbl_b.push_back(v(1, 1, 5, 5));    tbl_b.push_back(v(1, 1, 1023, 1023));
        tbl_b.push_back(v(0, 0, J, 3));
        tbl_b.push_back(v(0, 0, J, 1023)); tbl_b.push_back(v(0, 0, J, 0));
        tbl_b.push_back(v(0, 0, J, 1023)); tbl_b.push_back(v(0, 0, J, 1));
        tbl_b.push_back(v(1, 1, 100, 100)); tbl_b.push_back(v(1, 1, 200, 200));
        tbl_b.push_back(v(1, 0, J, 2));    tbl_b.push_back(v(1, 0, J, BW));
        tbl_b.push_back(v(0, 0, J, 3));    tbl_b.push_back(v(0, 0, J, BW));
        tbl_b.push_back(v(0, 0, J, 1023)); tbl_b.push_back(v(0, 0, J, 0));
        tbl_b.push_back(v(0, 0, J, 1023)); tbl_b.push_back(v(0, 0, J, 1));
        tbl_b.push_back(v(1, 1, 50, 50));  tbl_b.push_back(v(1, 1, 60, 60));
        tbl_b.push_back(v(1, 0, J, 2));
        tbl_b.push_back(v(1, 1, 70, 70));  tbl_b.push_back(v(1, 1, 80, 80));
        tbl_b.push_back(v(0, 0, J, 3));    tbl_b.push_back(v(0, 0, J, BW));

        step(1'b1, 1'b0, 1'b0, 10'd0);
        step(1'b1, 1'b0, 1'b0, 10'd0);
        apply_tbl(1'b0, "frame test");
        check("err after frame test", bus.err, 0);
        apply_tbl(1'b1, "clamp/late fall/short gap");
        check("err after short gap", bus.err, int'(ErrEn));
        repeat (8) step(1'b0, 1'b0, 1'b0, 10'd0);
        check("err sticky", bus.err, int'(ErrEn));

        // Reset in the middle of a line, then a clean frame must encode as before.
        repeat (6) step(1'b0, 1'b0, 1'b0, 10'd0);
        step(1'b0, 1'b1, 1'b1, 10'd11);
        step(1'b0, 1'b1, 1'b1, 10'd12);
        step(1'b0, 1'b1, 1'b1, 10'd13);
        step(1'b1, 1'b1, 1'b1, 10'd14);
        apply_tbl(1'b0, "frame after reset");
        check("err after reset frame", bus.err, 0);

        // fv rising on the first cycle after release.
        step(1'b1, 1'b0, 1'b0, 10'd0);
        step(1'b0, 1'b1, 1'b0, 10'd0);
        check("post-reset rise 1023", bus.data_out, 1023);
        step(1'b0, 1'b1, 1'b0, 10'd0);
        check("post-reset rise 0", bus.data_out, 0);

        for (int c = 0; c < 4000; c++) begin
            r = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 11) == 0) fv_s = !fv_s;
            if ($urandom_range(0, 3) == 0) lv_s = !lv_s;
            if ($urandom_range(0, 3) == 0) p = 10'($urandom_range(0, 6));
            else                           p = 10'($urandom_range(0, 1023));
            step(r, fv_s, lv_s & (fv_s | ($urandom_range(0, 7) == 0)), p);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
